// File: rtl/aggregator_flex.sv
// -----------------------------------------------------------------------------
// aggregator_flex
//
// Packs DATA_WIDTH words popped from a first-word-fall-through FIFO into one
// wide receiver word holding 1..MAX_FETCH_WIDTH words. The packing width can
// be changed at runtime. A width change or a flush first drains any partially
// filled group as a short group, then takes effect. The output stage is
// registered, and a new group may load in the same cycle the previous one is
// taken, so throughput is one word per cycle at every width.
//
// Ports
//   clk, rst_n           single clock, asynchronous active-low reset
//   sender_data          FIFO head word, valid while sender_empty_n is high
//   sender_empty_n       FIFO holds data
//   sender_deq           pop the FIFO head this cycle (combinational)
//   receiver_data        packed group; word k at [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH]
//   receiver_count       number of valid words in receiver_data
//   receiver_full_n      receiver can accept a group
//   receiver_enq         group transferred this cycle (combinational)
//   change_fetch_width   request a new width (sampled every cycle)
//   input_fetch_width    requested width; 0 is ignored, values above MAX are clamped
//   flush                emit the current partial group
//   busy                 words buffered, output valid, or width change pending
// -----------------------------------------------------------------------------
module aggregator_flex #(
   parameter int DATA_WIDTH          = 8,
   parameter int MAX_FETCH_WIDTH     = 8,
   parameter int DEFAULT_FETCH_WIDTH = 2,
   parameter int FW_BITS             = $clog2(MAX_FETCH_WIDTH + 1)
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic [DATA_WIDTH-1:0]                 sender_data,
   input  logic                                  sender_empty_n,
   output logic                                  sender_deq,
   output logic [MAX_FETCH_WIDTH*DATA_WIDTH-1:0] receiver_data,
   output logic [FW_BITS-1:0]                    receiver_count,
   input  logic                                  receiver_full_n,
   output logic                                  receiver_enq,
   input  logic                                  change_fetch_width,
   input  logic [FW_BITS-1:0]                    input_fetch_width,
   input  logic                                  flush,
   output logic                                  busy
);

   localparam int                 GROUP_BITS = MAX_FETCH_WIDTH * DATA_WIDTH;
   localparam logic [FW_BITS-1:0] MAX_FW     = FW_BITS'(MAX_FETCH_WIDTH);
   localparam logic [FW_BITS-1:0] DEFAULT_FW = FW_BITS'(DEFAULT_FETCH_WIDTH);
   localparam logic [FW_BITS-1:0] ONE_FW     = FW_BITS'(1);

   logic [FW_BITS-1:0]    fill_cnt;
   logic [FW_BITS-1:0]    active_width;
   logic [FW_BITS-1:0]    pending_width;
   logic                  pending;
   logic                  flush_active;
   logic                  out_valid;
   logic [GROUP_BITS-1:0] fill_buf;
   logic [GROUP_BITS-1:0] merged_buf;

   logic                  complete;
   logic                  out_free;
   logic                  draining;
   logic                  group_done;
   logic                  drain_emit;
   logic                  drain_idle;
   logic                  req_valid;
   logic [FW_BITS-1:0]    req_width;

   // fill_cnt < active_width <= MAX always holds, so the +1 cannot overflow.
   assign complete     = (fill_cnt + ONE_FW) == active_width;
   assign receiver_enq = out_valid & receiver_full_n;
   assign out_free     = ~out_valid | receiver_enq;
   assign draining     = pending | flush_active;

   // rst_n gates the pop so the FIFO is never read while the block is held
   // in reset, even though the control flops already read as idle.
   assign sender_deq = rst_n & sender_empty_n & ~draining & (~complete | out_free);
   assign group_done = sender_deq & complete;
   assign drain_emit = draining & (fill_cnt != '0) & out_free;
   assign drain_idle = draining & (fill_cnt == '0);

   assign busy = (fill_cnt != '0) | out_valid | pending;

   assign req_valid = change_fetch_width & (input_fetch_width != '0);
   assign req_width = (input_fetch_width > MAX_FW) ? MAX_FW : input_fetch_width;

   // Fill buffer with the head word dropped into slot fill_cnt. Slots above
   // fill_cnt are already zero, so this is both the next fill state and the
   // completed group.
   // NOTE: the default assignment first keeps this always_comb latch-free.
   always_comb begin
      merged_buf = fill_buf;
      for (int k = 0; k < MAX_FETCH_WIDTH; k++) begin
         if (fill_cnt == FW_BITS'(k)) begin
            merged_buf[k*DATA_WIDTH +: DATA_WIDTH] = sender_data;
         end
      end
   end

   // Datapath: fill buffer and registered output group.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // flop samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the fill buffer is reset, not just the count, because unused
         // slots of an emitted group must read as zero.
         fill_buf       <= '0;
         fill_cnt       <= '0;
         receiver_data  <= '0;
         receiver_count <= '0;
         out_valid      <= 1'b0;
      end else begin
         if (sender_deq) begin
            if (complete) begin
               receiver_data  <= merged_buf;
               receiver_count <= active_width;
               fill_buf       <= '0;
               fill_cnt       <= '0;
            end else begin
               fill_buf <= merged_buf;
               fill_cnt <= fill_cnt + ONE_FW;
            end
         end else if (drain_emit) begin
            receiver_data  <= fill_buf;
            receiver_count <= fill_cnt;
            fill_buf       <= '0;
            fill_cnt       <= '0;
         end

         // A load only happens when out_free, so it never overwrites a
         // group the receiver has not taken.
         if (group_done | drain_emit) begin
            out_valid <= 1'b1;
         end else if (receiver_enq) begin
            out_valid <= 1'b0;
         end
      end
   end

   // Control: flush tracking and width changes. Later statements win, so a
   // new flush or width request landing in the cycle the previous one
   // finishes is kept rather than lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flush_active  <= 1'b0;
         pending       <= 1'b0;
         pending_width <= DEFAULT_FW;
         active_width  <= DEFAULT_FW;
      end else begin
         // One partial-group emission satisfies both a flush and a pending
         // width change.
         if (drain_emit | drain_idle) begin
            flush_active <= 1'b0;
         end
         if (flush) begin
            flush_active <= 1'b1;
         end

         if (drain_idle & pending) begin
            active_width <= pending_width;
            pending      <= 1'b0;
         end
         if (req_valid) begin
            pending       <= 1'b1;
            pending_width <= req_width;
         end
      end
   end

endmodule

// File: tb/tb_aggregator_flex.sv
// -----------------------------------------------------------------------------
// tb_aggregator_flex
//
// Bench for aggregator_flex. A queue-based model of the packing rules predicts
// the handshakes, busy and the output group every cycle. A few hand-computed
// literal groups pin the model. A randomised phase checks that the received
// word stream equals the pushed word stream.
// -----------------------------------------------------------------------------
module tb_aggregator_flex;

   localparam int DW   = 8;
   localparam int MAXW = 8;
   localparam int DEFW = 2;
   localparam int FWB  = $clog2(MAXW + 1);
   localparam int GW   = DW * MAXW;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [DW-1:0]  sender_data = '0;
   logic           sender_empty_n = 1'b0;
   logic           sender_deq;
   logic [GW-1:0]  receiver_data;
   logic [FWB-1:0] receiver_count;
   logic           receiver_full_n = 1'b1;
   logic           receiver_enq;
   logic           change_fetch_width = 1'b0;
   logic [FWB-1:0] input_fetch_width = '0;
   logic           flush = 1'b0;
   logic           busy;

   aggregator_flex #(
      .DATA_WIDTH         (DW),
      .MAX_FETCH_WIDTH    (MAXW),
      .DEFAULT_FETCH_WIDTH(DEFW)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .sender_data       (sender_data),
      .sender_empty_n    (sender_empty_n),
      .sender_deq        (sender_deq),
      .receiver_data     (receiver_data),
      .receiver_count    (receiver_count),
      .receiver_full_n   (receiver_full_n),
      .receiver_enq      (receiver_enq),
      .change_fetch_width(change_fetch_width),
      .input_fetch_width (input_fetch_width),
      .flush             (flush),
      .busy              (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [GW-1:0] data;
      int            count;
   } grp_t;

   // Stimulus / scoreboard state
   logic [DW-1:0] fifo[$];
   logic [DW-1:0] f_in[$];
   logic [DW-1:0] f_out[$];
   bit            stall;
   bit            cap_on;
   int            n_vec;
   int            n_err;
   int            cyc;
   int            first_enq;

   // Model state: words of the group being filled, active width, pending
   // width request, flush request, and the group sitting at the output.
   logic [DW-1:0] m_buf[$];
   int            m_width;
   int            m_pw;
   bit            m_pend;
   bit            m_flush;
   bit            m_ov;
   logic [GW-1:0] m_odata;
   int            m_ocount;
   int            m_enq_total;
   grp_t          m_log[$];

   task automatic check(input string name, input logic [GW-1:0] act, input logic [GW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [GW-1:0] pack(input logic [DW-1:0] w[$]);
      logic [GW-1:0] d;
      d = '0;
      for (int i = 0; i < w.size(); i++) d[i*DW +: DW] = w[i];
      return d;
   endfunction

   task automatic drive();
      sender_data    = (fifo.size() != 0) ? fifo[0] : '0;
      sender_empty_n = (fifo.size() != 0) && !stall;
   endtask

   task automatic push(input logic [DW-1:0] w);
      fifo.push_back(w);
      if (cap_on) f_in.push_back(w);
      drive();
   endtask

   task automatic model_reset();
      m_buf.delete();
      m_width  = DEFW;
      m_pw     = DEFW;
      m_pend   = 1'b0;
      m_flush  = 1'b0;
      m_ov     = 1'b0;
      m_odata  = '0;
      m_ocount = 0;
   endtask

   // One clock cycle: compare at the falling edge, advance the model, then
   // pop the bench FIFO just after the rising edge if the model popped it.
   task automatic step();
      bit complete, e_enq, out_free, drain, e_deq, e_busy, load;
      @(negedge clk);
      complete = (m_buf.size() + 1 == m_width);
      e_enq    = m_ov && receiver_full_n;
      out_free = !m_ov || e_enq;
      drain    = m_pend || m_flush;
      e_deq    = sender_empty_n && !drain && (!complete || out_free);
      e_busy   = (m_buf.size() != 0) || m_ov || m_pend;

      check("sender_deq", 64'(sender_deq), 64'(e_deq));
      check("receiver_enq", 64'(receiver_enq), 64'(e_enq));
      check("busy", 64'(busy), 64'(e_busy));
      if (m_ov) begin
         check("receiver_data", receiver_data, m_odata);
         check("receiver_count", 64'(receiver_count), 64'(m_ocount));
      end

      if (cap_on && receiver_enq) begin
         for (int k = 0; k < int'(receiver_count) && k < MAXW; k++) begin
            f_out.push_back(receiver_data[k*DW +: DW]);
         end
      end
      if (e_enq) begin
         m_log.push_back('{m_odata, m_ocount});
         m_enq_total++;
         if (first_enq < 0) first_enq = cyc;
      end

      load = 1'b0;
      if (e_deq) begin
         m_buf.push_back(sender_data);
         if (complete) begin
            m_odata  = pack(m_buf);
            m_ocount = m_buf.size();
            m_buf.delete();
            load = 1'b1;
         end
      end else if (drain && m_buf.size() != 0 && out_free) begin
         m_odata  = pack(m_buf);
         m_ocount = m_buf.size();
         m_buf.delete();
         load    = 1'b1;
         m_flush = 1'b0;
      end else if (drain && m_buf.size() == 0) begin
         m_flush = 1'b0;
         if (m_pend) begin
            m_width = m_pw;
            m_pend  = 1'b0;
         end
      end
      if (load) m_ov = 1'b1;
      else if (e_enq) m_ov = 1'b0;
      if (flush) m_flush = 1'b1;
      if (change_fetch_width && input_fetch_width != '0) begin
         m_pend = 1'b1;
         m_pw   = (int'(input_fetch_width) > MAXW) ? MAXW : int'(input_fetch_width);
      end

      @(posedge clk);
      #1;
      cyc++;
      if (e_deq && fifo.size() != 0) void'(fifo.pop_front());
      drive();
   endtask

   task automatic steps(input int n);
      repeat (n) step();
   endtask

   task automatic req_width(input int w);
      change_fetch_width = 1'b1;
      input_fetch_width  = FWB'(w);
      step();
      change_fetch_width = 1'b0;
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      step();
      flush = 1'b0;
   endtask

   task automatic check_log(input string name, input int idx, input logic [GW-1:0] d, input int c);
      if (idx >= m_log.size()) begin
         check({name, "_present"}, 64'(m_log.size()), 64'(idx + 1));
      end else begin
         check({name, "_data"}, m_log[idx].data, d);
         check({name, "_count"}, 64'(m_log[idx].count), 64'(c));
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_deq"}, 64'(sender_deq), 64'(0));
      check({tag, "_enq"}, 64'(receiver_enq), 64'(0));
      check({tag, "_busy"}, 64'(busy), 64'(0));
      check({tag, "_data"}, receiver_data, 64'(0));
      check({tag, "_count"}, 64'(receiver_count), 64'(0));
   endtask

   initial begin
      int base;
      int e0;
      int sz;
      int r;
      n_vec = 0;
      n_err = 0;
      cyc = 0;
      first_enq = -1;
      m_enq_total = 0;
      stall = 1'b0;
      cap_on = 1'b0;
      model_reset();

      // Reset with data waiting: nothing may be popped or sent.
      for (int i = 0; i < 8; i++) push(DW'(i));
      @(posedge clk);
      @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;

      // Width 2 stream 0..7: group n = {2n, 2n+1}, first transfer two cycles in.
      steps(12);
      check("first_enq_cycle", 64'(first_enq), 64'(2));
      check_log("w2_grp0", 0, 64'h0100, 2);
      check_log("w2_grp3", 3, 64'h0706, 2);

      // Word 4 buffered at width 2, switch to 4: partial {4}, then {5,6,7,8}.
      base = m_log.size();
      push(8'd4);
      steps(3);
      req_width(4);
      steps(4);
      for (int i = 5; i <= 8; i++) push(DW'(i));
      steps(8);
      check_log("chg_partial", base, 64'h04, 1);
      check_log("chg_w4", base + 1, 64'h08070605, 4);

      // Flush with three words buffered, then a flush with nothing buffered.
      base = m_log.size();
      push(8'd10);
      push(8'd11);
      push(8'd12);
      steps(5);
      pulse_flush();
      steps(4);
      check_log("flush_partial", base, 64'h0C0B0A, 3);
      sz = m_log.size();
      pulse_flush();
      steps(4);
      check("flush_empty_no_enq", 64'(m_log.size()), 64'(sz));

      // Width 1: twelve words, twelve transfers in fourteen cycles.
      req_width(1);
      steps(3);
      base = m_log.size();
      e0 = m_enq_total;
      for (int i = 0; i < 12; i++) push(DW'(20 + i));
      steps(14);
      check("w1_no_bubble", 64'(m_enq_total - e0), 64'(12));
      check_log("w1_first", base, 64'h14, 1);
      check_log("w1_last", base + 11, 64'h1F, 1);

      // Width 1 with a three-cycle receiver stall: nothing lost or repeated.
      for (int i = 0; i < 6; i++) push(DW'(32 + i));
      steps(2);
      receiver_full_n = 1'b0;
      steps(3);
      receiver_full_n = 1'b1;
      steps(8);
      check_log("stall_first", base + 12, 64'h20, 1);
      check_log("stall_last", base + 17, 64'h25, 1);

      // Width 0 is ignored (stays 1); 15 clamps to 8.
      base = m_log.size();
      req_width(0);
      steps(3);
      push(8'd40);
      push(8'd41);
      steps(4);
      check_log("w0_ignored_a", base, 64'h28, 1);
      check_log("w0_ignored_b", base + 1, 64'h29, 1);
      req_width(15);
      steps(3);
      base = m_log.size();
      for (int i = 0; i < 8; i++) push(DW'(50 + i));
      steps(12);
      check_log("w15_clamped", base, 64'h3938373635343332, 8);
      steps(4);

      // Random FIFO stalls, receiver back-pressure, width changes and flushes.
      cap_on = 1'b1;
      req_width(3);
      for (int i = 0; i < 2000; i++) begin
         stall = ($urandom_range(0, 3) == 0);
         receiver_full_n = ($urandom_range(0, 3) != 0);
         if (fifo.size() < 12 && $urandom_range(0, 1) == 1) push(DW'($urandom));
         r = $urandom_range(0, 99);
         if (r < 2) begin
            change_fetch_width = 1'b1;
            input_fetch_width  = FWB'($urandom_range(0, 15));
         end else if (r < 4) begin
            flush = 1'b1;
         end
         drive();
         step();
         change_fetch_width = 1'b0;
         flush = 1'b0;
      end
      stall = 1'b0;
      receiver_full_n = 1'b1;
      drive();
      steps(40);
      pulse_flush();
      steps(10);
      cap_on = 1'b0;
      check("stream_len", 64'(f_out.size()), 64'(f_in.size()));
      for (int i = 0; i < f_in.size() && i < f_out.size(); i++) begin
         check("stream_word", 64'(f_out[i]), 64'(f_in[i]));
      end

      // Reset mid-group: buffered words vanish, restart at the default width.
      req_width(4);
      steps(3);
      push(8'd60);
      push(8'd61);
      push(8'd62);
      steps(4);
      push(8'd63);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_reset");
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      base = m_log.size();
      push(8'd64);
      steps(4);
      check_log("after_reset", base, 64'h403F, 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/aggregator_flex.md
Name: aggregator_flex

Overview:
Runtime-reconfigurable successor to the word aggregator. Dequeues DATA_WIDTH words from a FIFO (FWFT, SyncFIFO read side) and packs 1..MAX_FETCH_WIDTH of them into one wide receiver word. The block adds a registered output stage for full throughput, safe width changes mid-group (partial-group drain), explicit flush, and a valid-count output. It sits between the clock-crossing SyncFIFO and downstream wide consumers.

Parameters:
DATA_WIDTH, 8, bits per sender word
MAX_FETCH_WIDTH, 8, maximum words per packed output (>=1)
DEFAULT_FETCH_WIDTH, 2, active width after reset (1..MAX_FETCH_WIDTH)
FW_BITS, $clog2(MAX_FETCH_WIDTH+1), width of width/count fields (derived; do not override)

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous active-low reset
sender_data  in  DATA_WIDTH  FIFO head word, valid when sender_empty_n
sender_empty_n  in  1  FIFO has data
sender_deq  out  1  pop FIFO this cycle (combinational)
receiver_data  out  MAX_FETCH_WIDTH*DATA_WIDTH  packed group; word k at bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH]
receiver_count  out  FW_BITS  number of valid words in receiver_data
receiver_full_n  in  1  receiver can accept
receiver_enq  out  1  transfer this cycle (combinational)
change_fetch_width  in  1  request width change, sampled each cycle
input_fetch_width  in  FW_BITS  requested width
flush  in  1  emit current partial group
busy  out  1  fill count nonzero, output valid, or change pending

Behaviour:
- Reset (async): fill count 0, fill buffer 0, out_valid 0, receiver_data 0, receiver_count 0, active width = DEFAULT_FETCH_WIDTH, no pending change. sender_deq and receiver_enq are 0 while rst_n is low.
- receiver_enq = out_valid & receiver_full_n. receiver_data/count are registered and held stable while out_valid & !receiver_full_n.
- Packing: the first word of a group goes to slot 0. Unused slots (>= count) are 0.
- complete = (cnt+1 == width). out_free = !out_valid | receiver_enq.
- sender_deq = sender_empty_n & !pending & !flush_active & (!complete | out_free).
- On deq with !complete: buffer[cnt] <= sender_data; cnt++.
- On deq with complete: receiver_data <= buffer with sender_data in slot cnt; count <= width; out_valid <= 1; cnt <= 0; buffer cleared. Latency: the last word is visible on receiver_data one cycle after its deq.
- Sustained rate is 1 word/cycle at any width, including width 1, when receiver_full_n stays 1.
- out_valid clears after receiver_enq unless reloaded in the same cycle.
- Width request: change_fetch_width=1 latches a clamped width into pending_width and sets pending. Clamping: 0 → request ignored; >MAX → MAX. A later request overwrites an earlier one.
- While pending: no deq. If cnt>0, the partial group is emitted when out_free, with count=cnt, then cnt <= 0. Once cnt==0, active width <= pending_width and pending clears. sender_deq may assert the following cycle. A request equal to the active width with cnt==0 completes in 1 cycle.
- flush=1 sets flush_active. Deq is blocked. If cnt>0, the partial group is emitted when out_free and flush_active clears. If cnt==0, flush_active clears next cycle with no emission.
- A flush and a width change in the same cycle drain one partial group only, then apply the new width.
- Counts never exceed MAX_FETCH_WIDTH; cnt never wraps.
- Reset mid-group or mid-drain discards all data with no enq. The FIFO is not re-read.

Test Plan:
- Width 2, incrementing FIFO data 0,1,2,..., receiver_full_n=1 → slot0=2n, slot1=2n+1, count=2; one enq every 2 deqs; data appears 1 cycle after the last deq.
- Width 2 with cnt=1 (word 4 buffered), then change to 4 → one enq with slot0=4, count=1, other slots 0; subsequent groups {5,6,7,8} with count=4.
- Width 1 with receiver_full_n=1 continuously → one enq per cycle with slot0=sequence and no bubbles. Drop receiver_full_n for 3 cycles → data held, at most 1 deq more, then stall; no loss.
- Width 4 with words 10,11,12 buffered, flush pulse → enq with {10,11,12,0}, count=3. Flush with cnt=0 → no enq.
- Request width 0 → ignored (width stays). Request 15 with MAX=8 → 8-word groups.
- Random stall on FIFO write side and random receiver_full_n over 2000 cycles → output stream equals input stream in order. Assert rst_n low mid-group → receiver_enq=0, busy=0, restart at DEFAULT_FETCH_WIDTH.
